in_debounce: RTL and testbench

//  Input-conditioning stage feeding the half-adder/logic stage: synchronises raw pad bits
//  (ui_in[1:0]) to clk, rejects bounce and glitches, and presents clean levels plus
//  one-cycle edge strobes. Downstream logic consumes db_out in place of raw ui_in bits.

---
 rtl/in_debounce_pkg.sv | 13 +
 rtl/in_debounce_ch.sv | 82 ++++++++
 rtl/in_debounce.sv | 73 +++++++
 tb/tb_in_debounce.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/in_debounce_pkg.sv
// rtl/in_debounce_pkg.sv - shared types and sizing helpers for the input debouncer
// Used by in_debounce and in_debounce_ch.
package in_debounce_pkg;

  typedef enum logic {ST_STABLE, ST_CHECK} db_state_t;

  localparam int GLITCH_W = 8;

  function automatic int cnt_w(input int db_cycles);
    return (db_cycles > 2) ? $clog2(db_cycles) : 1;
  endfunction

endpackage

// File: rtl/in_debounce_ch.sv
// rtl/in_debounce_ch.sv - one debounce channel: qualify FSM, level, edge strobes, glitch event
// Consumes an already-synchronised bit; glitch is a combinational per-cycle event.
module in_debounce_ch
  import in_debounce_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic sync_q,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic stable,
  output logic glitch
);

  localparam int CNT_W = cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_d;
  logic             db_dly;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_out;
    glitch  = 1'b0;
    if (ena) begin
      case (state_q)
        ST_STABLE: begin
          if (sync_q != db_out) begin
            state_d = ST_CHECK;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (sync_q == db_out) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            glitch  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            db_d    = sync_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Strobes come from comparing db_out with its one-cycle-old copy, so they land the cycle after the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STABLE;
      cnt_q      <= '0;
      db_out     <= 1'b0;
      db_dly     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_out     <= db_d;
      db_dly     <= db_out;
      rise_pulse <= ena & db_out & ~db_dly;
      fall_pulse <= ena & ~db_out & db_dly;
    end
  end

  assign stable = (state_q == ST_STABLE);

endmodule

// File: rtl/in_debounce.sv
// rtl/in_debounce.sv - synchronise and debounce WIDTH raw pad inputs into clean levels and strobes
// Define IN_DEBOUNCE_GLITCH_CNT_EN to build the saturating rejected-glitch counter.
module in_debounce
  import in_debounce_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [WIDTH-1:0]    raw_in,
  output logic [WIDTH-1:0]    db_out,
  output logic [WIDTH-1:0]    rise_pulse,
  output logic [WIDTH-1:0]    fall_pulse,
  output logic                stable,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] ch_stable;
  logic [WIDTH-1:0] ch_glitch;

  // The chain keeps sampling while ena is low so resuming never sees stale pad data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    in_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .sync_q     (sync_q[i]),
      .db_out     (db_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .stable     (ch_stable[i]),
      .glitch     (ch_glitch[i])
    );
  end

  assign stable = &ch_stable;

`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W:0] glitch_sum;

  always_comb begin
    glitch_sum = {1'b0, glitch_cnt};
    for (int i = 0; i < WIDTH; i++) glitch_sum = glitch_sum + (GLITCH_W+1)'(ch_glitch[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_cnt <= '0;
    else if (glitch_sum[GLITCH_W]) glitch_cnt <= '1;
    else glitch_cnt <= glitch_sum[GLITCH_W-1:0];
  end
`else
  logic glitch_unused;
  assign glitch_unused = |ch_glitch;
  assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_in_debounce.sv
// tb/tb_in_debounce.sv - directed self-checking bench for in_debounce (2 ch, 2 sync, 16 cycles)
// Expected glitch counts follow IN_DEBOUNCE_GLITCH_CNT_EN.
module tb_in_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] raw_in;
  logic [1:0] db_out, rise_pulse, fall_pulse;
  logic       stable;
  logic [7:0] glitch_cnt;

  int passed = 0;
  int total  = 0;

  in_debounce #(.WIDTH(2), .SYNC_STAGES(2), .DB_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .stable     (stable),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gexp(input int n);
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n > 255) ? 8'h00 : 8'h00;
`endif
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b1; raw_in = 2'b11;
    tick(3);
    chk("rst_db", 8'(db_out), 8'h00);
    chk("rst_rise", 8'(rise_pulse), 8'h00);
    chk("rst_fall", 8'(fall_pulse), 8'h00);
    chk("rst_stable", 8'(stable), 8'h01);
    chk("rst_gcnt", glitch_cnt, 8'h00);
    raw_in = 2'b00;
    rst = 1'b0;
    tick(4);
    chk("idle_stable", 8'(stable), 8'h01);

    // Clean step on channel 0
    raw_in = 2'b01;
    tick(2);
    chk("step_e2_stable", 8'(stable), 8'h01);
    tick(1);
    chk("step_e3_stable", 8'(stable), 8'h00);
    tick(14);
    chk("step_e17_db", 8'(db_out), 8'h00);
    chk("step_e17_stable", 8'(stable), 8'h00);
    tick(1);
    chk("step_e18_db", 8'(db_out), 8'h01);
    chk("step_e18_rise", 8'(rise_pulse), 8'h00);
    chk("step_e18_stable", 8'(stable), 8'h01);
    tick(1);
    chk("step_e19_rise", 8'(rise_pulse), 8'h01);
    chk("step_e19_fall", 8'(fall_pulse), 8'h00);
    tick(1);
    chk("step_e20_rise", 8'(rise_pulse), 8'h00);

    // Five-cycle bounce on channel 1
    raw_in = 2'b11;
    tick(5);
    raw_in = 2'b01;
    tick(12);
    chk("bounce_db", 8'(db_out), 8'h01);
    chk("bounce_stable", 8'(stable), 8'h01);
    chk("bounce_gcnt", glitch_cnt, gexp(1));

    // ena dropped with channel 1 at cnt=8
    raw_in = 2'b11;
    tick(10);
    ena = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("hold_pulses", 8'({rise_pulse, fall_pulse}), 8'h00);
      chk("hold_db", 8'(db_out), 8'h01);
    end
    chk("hold_stable", 8'(stable), 8'h00);
    ena = 1'b1;
    tick(7);
    chk("resume_7_db", 8'(db_out), 8'h01);
    tick(1);
    chk("resume_8_db", 8'(db_out), 8'h03);
    tick(1);
    chk("resume_rise", 8'(rise_pulse), 8'h02);

    // Both channels fall together
    raw_in = 2'b00;
    tick(17);
    chk("sim_e17_db", 8'(db_out), 8'h03);
    tick(1);
    chk("sim_e18_db", 8'(db_out), 8'h00);
    chk("sim_e18_fall", 8'(fall_pulse), 8'h00);
    tick(1);
    chk("sim_e19_fall", 8'(fall_pulse), 8'h03);
    chk("sim_e19_rise", 8'(rise_pulse), 8'h00);
    tick(1);
    chk("sim_e20_fall", 8'(fall_pulse), 8'h00);

    // Single-cycle spikes on both channels: two glitch events each
    for (int b = 0; b < 150; b++) begin
      raw_in = 2'b11;
      tick(1);
      raw_in = 2'b00;
      tick(3);
      if (b == 99) chk("gcnt_201", glitch_cnt, gexp(201));
    end
    chk("gcnt_sat", glitch_cnt, gexp(301));
    chk("spike_db", 8'(db_out), 8'h00);
    tick(8);
    chk("gcnt_sat_hold", glitch_cnt, gexp(301));

    // Reset while channel 0 is at cnt=10
    raw_in = 2'b01;
    tick(12);
    chk("pre_rst_stable", 8'(stable), 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst_db", 8'(db_out), 8'h00);
    chk("midrst_stable", 8'(stable), 8'h01);
    chk("midrst_gcnt", glitch_cnt, 8'h00);
    tick(2);
    chk("midrst_rise", 8'(rise_pulse), 8'h00);
    rst = 1'b0;
    tick(17);
    chk("requal_e17_db", 8'(db_out), 8'h00);
    tick(1);
    chk("requal_e18_db", 8'(db_out), 8'h01);
    tick(1);
    chk("requal_rise", 8'(rise_pulse), 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
